// File: rtl/wb_pkg.sv
// ---------------------------------------------------------------------------
// wb_pkg
// Shared types and constants for the register-file write-back unit.
//   XLEN      : register data width
//   REG_AW    : register index width (32 architectural registers)
//   wb_entry_t: one slow-path queue slot {valid, rd, data}
//   wb_sel_e  : write-port arbitration outcome for a cycle
//   fwd_t     : forwarding result {hit, data}
//   fwd_select: priority mux shared by both forwarding operands
// ---------------------------------------------------------------------------
package wb_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_entry_t;

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,  // nothing to write, port idles
    SEL_ALU  = 2'd1,  // ALU result takes the port
    SEL_HEAD = 2'd2,  // live queue head is written and popped
    SEL_DROP = 2'd3   // squashed queue head is popped without a write
  } wb_sel_e;

  typedef struct packed {
    logic            hit;
    logic [XLEN-1:0] data;
  } fwd_t;

  // Forwarding priority: x0 never forwards; queued results are younger than
  // whatever sits in the output register, so a queue hit wins over it.
  function automatic fwd_t fwd_select(
    input logic [REG_AW-1:0] rs,
    input logic              q_hit,
    input logic [XLEN-1:0]   q_data,
    input logic              out_we,
    input logic [REG_AW-1:0] out_rd,
    input logic [XLEN-1:0]   out_data
  );
    fwd_t res;
    res.hit  = 1'b0;
    res.data = '0;
    if (rs != '0) begin
      if (q_hit) begin
        res.hit  = 1'b1;
        res.data = q_data;
      end else if (out_we && (out_rd == rs)) begin
        res.hit  = 1'b1;
        res.data = out_data;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/wb_queue.sv
// ---------------------------------------------------------------------------
// wb_queue
// In-order circular buffer for slow-path (load/multiply) results.
// Entries can be invalidated in place (squashed) by rd match; a squashed slot
// stays occupied until it reaches the head and is popped.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   i_push          : write {i_push_rd, i_push_data} at the tail
//   i_pop           : retire the head slot (live or squashed)
//   i_squash        : invalidate every slot whose rd equals i_squash_rd,
//                     including the slot being pushed in the same cycle
//   o_head          : head slot contents, o_head_occ says it is occupied
//   o_full, o_count : occupancy (squashed slots included)
//   i_rs1/i_rs2     : search keys; o_hit*/o_data* give the youngest live match
// ---------------------------------------------------------------------------
module wb_queue
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_push,
  input  logic [REG_AW-1:0]         i_push_rd,
  input  logic [XLEN-1:0]           i_push_data,
  input  logic                      i_pop,
  input  logic                      i_squash,
  input  logic [REG_AW-1:0]         i_squash_rd,
  output wb_entry_t                 o_head,
  output logic                      o_head_occ,
  output logic                      o_full,
  output logic [$clog2(DEPTH):0]    o_count,
  input  logic [REG_AW-1:0]         i_rs1,
  input  logic [REG_AW-1:0]         i_rs2,
  output logic                      o_hit1,
  output logic [XLEN-1:0]           o_data1,
  output logic                      o_hit2,
  output logic [XLEN-1:0]           o_data2
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DEPTH-1:0]  r_valid;
  logic [REG_AW-1:0] r_rd   [DEPTH];
  logic [XLEN-1:0]   r_data [DEPTH];
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [CNT_W-1:0]  r_count;

  // A push that collides with a same-cycle squash lands already invalid.
  logic w_push_valid;
  assign w_push_valid = !(i_squash && (i_push_rd == i_squash_rd));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (i_squash && (r_rd[i] == i_squash_rd)) begin
          r_valid[i] <= 1'b0;
        end
      end
      if (i_pop) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + PTR_W'(1);
      end
      // The tail slot is never occupied when pushing, so this override of the
      // squash loop above only touches a free slot.
      if (i_push) begin
        r_valid[r_tail] <= w_push_valid;
        r_rd[r_tail]    <= i_push_rd;
        r_data[r_tail]  <= i_push_data;
        r_tail          <= r_tail + PTR_W'(1);
      end
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head.valid = r_valid[r_head];
  assign o_head.rd    = r_rd[r_head];
  assign o_head.data  = r_data[r_head];
  assign o_head_occ   = (r_count != '0);
  assign o_full       = (r_count == CNT_W'(DEPTH));
  assign o_count      = r_count;

  // Per-slot liveness: occupied (age below count) and not squashed.
  logic [DEPTH-1:0] w_live;
  logic [DEPTH-1:0] w_match [2];
  logic [REG_AW-1:0] w_key  [2];
  logic              w_hit  [2];
  logic [XLEN-1:0]   w_data [2];

  assign w_key[0] = i_rs1;
  assign w_key[1] = i_rs2;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_slot
      logic [PTR_W-1:0] w_age;
      assign w_age      = PTR_W'(gi) - r_head;
      assign w_live[gi] = r_valid[gi] && ({1'b0, w_age} < r_count);
      assign w_match[0][gi] = w_live[gi] && (r_rd[gi] == w_key[0]);
      assign w_match[1][gi] = w_live[gi] && (r_rd[gi] == w_key[1]);
    end

    // Walk slots oldest to youngest; a later match overrides an earlier one
    // so the youngest live producer is reported.
    for (gi = 0; gi < 2; gi++) begin : g_search
      logic [PTR_W-1:0] v_idx;
      always_comb begin
        w_hit[gi]  = 1'b0;
        w_data[gi] = '0;
        v_idx      = r_head;
        for (int a = 0; a < DEPTH; a++) begin
          v_idx = r_head + PTR_W'(a);
          if (w_match[gi][v_idx]) begin
            w_hit[gi]  = 1'b1;
            w_data[gi] = r_data[v_idx];
          end
        end
      end
    end
  endgenerate

  assign o_hit1  = w_hit[0];
  assign o_data1 = w_data[0];
  assign o_hit2  = w_hit[1];
  assign o_data2 = w_data[1];

endmodule

// File: rtl/regfile_writeback_unit.sv
// ---------------------------------------------------------------------------
// regfile_writeback_unit
// Merges the single-cycle ALU path and the variable-latency slow path into the
// register file's single write port, and forwards pending results to decode.
// Ports:
//   clk, rst                        : clock, synchronous active-high reset
//   alu_valid/alu_rd/alu_data       : ALU result, always accepted
//   mem_valid/mem_ready/mem_rd/
//   mem_data                        : slow-path result handshake
//   RegWrite/WriteRegister/WriteData: registered register-file write port
//   fwd_rs1/fwd_rs2                 : decode source indices
//   fwd_hit*/fwd_data*              : combinational forwarding results
//   pending_cnt                     : queue occupancy incl. squashed slots
// ---------------------------------------------------------------------------
module regfile_writeback_unit
  import wb_pkg::*;
#(
  parameter int DEPTH = 4  // power of two, at least 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    alu_valid,
  input  logic [REG_AW-1:0]       alu_rd,
  input  logic [XLEN-1:0]         alu_data,
  input  logic                    mem_valid,
  output logic                    mem_ready,
  input  logic [REG_AW-1:0]       mem_rd,
  input  logic [XLEN-1:0]         mem_data,
  output logic                    RegWrite,
  output logic [REG_AW-1:0]       WriteRegister,
  output logic [XLEN-1:0]         WriteData,
  input  logic [REG_AW-1:0]       fwd_rs1,
  input  logic [REG_AW-1:0]       fwd_rs2,
  output logic                    fwd_hit1,
  output logic                    fwd_hit2,
  output logic [XLEN-1:0]         fwd_data1,
  output logic [XLEN-1:0]         fwd_data2,
  output logic [$clog2(DEPTH):0]  pending_cnt
);

  logic              r_reg_write;
  logic [REG_AW-1:0] r_write_reg;
  logic [XLEN-1:0]   r_write_data;

  wb_entry_t         w_head;
  logic              w_head_occ;
  logic              w_full;
  logic              w_alu_wr;
  logic              w_push;
  logic              w_pop;
  wb_sel_e           w_sel;
  logic              w_q_hit1;
  logic              w_q_hit2;
  logic [XLEN-1:0]   w_q_data1;
  logic [XLEN-1:0]   w_q_data2;
  fwd_t              w_fwd1;
  fwd_t              w_fwd2;

  // x0 is hard-wired: an ALU result to x0 neither writes nor squashes, and a
  // slow-path result to x0 is accepted but never stored.
  assign w_alu_wr  = alu_valid && (alu_rd != '0);
  // mem_ready depends only on registered occupancy, never on mem_valid or on
  // a same-cycle pop.
  assign mem_ready = !w_full;
  assign w_push    = mem_valid && mem_ready && (mem_rd != '0);

  always_comb begin
    w_sel = SEL_NONE;
    if (w_alu_wr) begin
      w_sel = SEL_ALU;
    end else if (w_head_occ && w_head.valid) begin
      w_sel = SEL_HEAD;
    end else if (w_head_occ) begin
      w_sel = SEL_DROP;
    end
  end

  assign w_pop = (w_sel == SEL_HEAD) || (w_sel == SEL_DROP);

  wb_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_push),
    .i_push_rd   (mem_rd),
    .i_push_data (mem_data),
    .i_pop       (w_pop),
    .i_squash    (w_alu_wr),
    .i_squash_rd (alu_rd),
    .o_head      (w_head),
    .o_head_occ  (w_head_occ),
    .o_full      (w_full),
    .o_count     (pending_cnt),
    .i_rs1       (fwd_rs1),
    .i_rs2       (fwd_rs2),
    .o_hit1      (w_q_hit1),
    .o_data1     (w_q_data1),
    .o_hit2      (w_q_hit2),
    .o_data2     (w_q_data2)
  );

  // Output register: index/data hold their last value on idle cycles so the
  // register file only sees changes when RegWrite is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_reg_write  <= 1'b0;
      r_write_reg  <= '0;
      r_write_data <= '0;
    end else begin
      case (w_sel)
        SEL_ALU: begin
          r_reg_write  <= 1'b1;
          r_write_reg  <= alu_rd;
          r_write_data <= alu_data;
        end
        SEL_HEAD: begin
          r_reg_write  <= 1'b1;
          r_write_reg  <= w_head.rd;
          r_write_data <= w_head.data;
        end
        default: begin
          r_reg_write  <= 1'b0;
        end
      endcase
    end
  end

  assign RegWrite      = r_reg_write;
  assign WriteRegister = r_write_reg;
  assign WriteData     = r_write_data;

  // Same-cycle arrivals are deliberately not forwarded; decode stalls a cycle.
  assign w_fwd1 = fwd_select(fwd_rs1, w_q_hit1, w_q_data1,
                             r_reg_write, r_write_reg, r_write_data);
  assign w_fwd2 = fwd_select(fwd_rs2, w_q_hit2, w_q_data2,
                             r_reg_write, r_write_reg, r_write_data);

  assign fwd_hit1  = w_fwd1.hit;
  assign fwd_data1 = w_fwd1.data;
  assign fwd_hit2  = w_fwd2.hit;
  assign fwd_data2 = w_fwd2.data;

endmodule

// File: tb/tb_regfile_writeback_unit.sv
module tb_regfile_writeback_unit;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        mem_valid;
  logic        mem_ready;
  logic [4:0]  mem_rd;
  logic [31:0] mem_data;
  logic        RegWrite;
  logic [4:0]  WriteRegister;
  logic [31:0] WriteData;
  logic [4:0]  fwd_rs1;
  logic [4:0]  fwd_rs2;
  logic        fwd_hit1;
  logic        fwd_hit2;
  logic [31:0] fwd_data1;
  logic [31:0] fwd_data2;
  logic [2:0]  pending_cnt;

  regfile_writeback_unit #(.DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .alu_valid     (alu_valid),
    .alu_rd        (alu_rd),
    .alu_data      (alu_data),
    .mem_valid     (mem_valid),
    .mem_ready     (mem_ready),
    .mem_rd        (mem_rd),
    .mem_data      (mem_data),
    .RegWrite      (RegWrite),
    .WriteRegister (WriteRegister),
    .WriteData     (WriteData),
    .fwd_rs1       (fwd_rs1),
    .fwd_rs2       (fwd_rs2),
    .fwd_hit1      (fwd_hit1),
    .fwd_hit2      (fwd_hit2),
    .fwd_data1     (fwd_data1),
    .fwd_data2     (fwd_data2),
    .pending_cnt   (pending_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int w7     = 0;

  // Reference model: an ordered list of pending results, oldest first.
  typedef struct {
    bit          live;
    logic [4:0]  rd;
    logic [31:0] data;
  } ment_t;
  ment_t       mq[$];
  bit          m_rw;
  logic [4:0]  m_wr;
  logic [31:0] m_wd;

  logic [31:0] dut_rf [32];
  logic [36:0] wlog[$];

  typedef struct {
    bit          av;
    logic [4:0]  ard;
    logic [31:0] ad;
    bit          mv;
    logic [4:0]  mrd;
    logic [31:0] md;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    bit          e_rw;
    logic [4:0]  e_wr;
    logic [31:0] e_wd;
    bit          e_rdy;
    int          e_cnt;
    bit          e_h1;
    logic [31:0] e_d1;
    bit          e_h2;
    logic [31:0] e_d2;
  } vec_t;

  function automatic vec_t mk(int av, int ard, int ad, int mv, int mrd, int md,
                              int rs1, int rs2, int rw, int wr, int wd, int rdy,
                              int cnt, int h1, int d1, int h2, int d2);
    vec_t v;
    v.av = av[0]; v.ard = 5'(ard); v.ad = 32'(ad);
    v.mv = mv[0]; v.mrd = 5'(mrd); v.md = 32'(md);
    v.rs1 = 5'(rs1); v.rs2 = 5'(rs2);
    v.e_rw = rw[0]; v.e_wr = 5'(wr); v.e_wd = 32'(wd);
    v.e_rdy = rdy[0]; v.e_cnt = cnt;
    v.e_h1 = h1[0]; v.e_d1 = 32'(d1); v.e_h2 = h2[0]; v.e_d2 = 32'(d2);
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_rw = 1'b0;
    m_wr = '0;
    m_wd = '0;
  endtask

  // One clock of the write-back rules, applied to the ordered list.
  task automatic model_step(input bit av, input logic [4:0] ard, input logic [31:0] ad,
                            input bit mv, input logic [4:0] mrd, input logic [31:0] md);
    int    pre;
    bit    aw;
    ment_t e;
    pre = mq.size();
    aw  = av && (ard != 0);
    if (aw) begin
      m_rw = 1'b1; m_wr = ard; m_wd = ad;
    end else if (pre > 0) begin
      e = mq.pop_front();
      if (e.live) begin
        m_rw = 1'b1; m_wr = e.rd; m_wd = e.data;
      end else begin
        m_rw = 1'b0;
      end
    end else begin
      m_rw = 1'b0;
    end
    if (mv && (pre < DEPTH) && (mrd != 0)) mq.push_back('{1'b1, mrd, md});
    if (aw) begin
      foreach (mq[i]) if (mq[i].rd == ard) mq[i].live = 1'b0;
    end
  endtask

  task automatic model_fwd(input logic [4:0] rs, output bit hit, output logic [31:0] d);
    hit = 1'b0;
    d   = '0;
    if (rs != 0) begin
      for (int i = mq.size() - 1; i >= 0; i--) begin
        if (mq[i].live && mq[i].rd == rs) begin
          hit = 1'b1; d = mq[i].data; return;
        end
      end
      if (m_rw && m_wr == rs) begin
        hit = 1'b1; d = m_wd;
      end
    end
  endtask

  task automatic step(input bit r, input bit av, input logic [4:0] ard, input logic [31:0] ad,
                      input bit mv, input logic [4:0] mrd, input logic [31:0] md,
                      input logic [4:0] s1, input logic [4:0] s2);
    bit          h1, h2;
    logic [31:0] d1, d2;
    @(negedge clk);
    rst = r; alu_valid = av; alu_rd = ard; alu_data = ad;
    mem_valid = mv; mem_rd = mrd; mem_data = md; fwd_rs1 = s1; fwd_rs2 = s2;
    @(posedge clk);
    if (r) model_reset();
    else   model_step(av, ard, ad, mv, mrd, md);
    cyc++;
    #1;
    model_fwd(s1, h1, d1);
    model_fwd(s2, h2, d2);
    check("RegWrite", 32'(RegWrite), 32'(m_rw));
    check("WriteRegister", 32'(WriteRegister), 32'(m_wr));
    check("WriteData", WriteData, m_wd);
    check("mem_ready", 32'(mem_ready), 32'(mq.size() < DEPTH));
    check("pending_cnt", 32'(pending_cnt), 32'(mq.size()));
    check("fwd_hit1", 32'(fwd_hit1), 32'(h1));
    check("fwd_data1", fwd_data1, d1);
    check("fwd_hit2", 32'(fwd_hit2), 32'(h2));
    check("fwd_data2", fwd_data2, d2);
    if (RegWrite === 1'b1) begin
      dut_rf[WriteRegister] = WriteData;
      wlog.push_back({WriteRegister, WriteData});
      if (WriteRegister == 5'd7) w7++;
    end
  endtask

  task automatic idle(input logic [4:0] s1, input logic [4:0] s2);
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, s1, s2);
  endtask

  vec_t vecs[14];

  initial begin
    int k;
    rst = 1'b1; alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    mem_valid = 1'b0; mem_rd = '0; mem_data = '0; fwd_rs1 = '0; fwd_rs2 = '0;
    foreach (dut_rf[i]) dut_rf[i] = '0;
    model_reset();

    //               av ard ad      mv mrd md      rs1 rs2 rw wr wd      rdy cnt h1 d1      h2 d2
    vecs[0]  = mk(0, 0, 0,      0, 0, 0,      5, 0,  0, 0, 0,      1, 0,  0, 0,      0, 0);
    vecs[1]  = mk(1, 3, 'h11,   1, 4, 'h22,   3, 4,  1, 3, 'h11,   1, 1,  1, 'h11,   1, 'h22);
    vecs[2]  = mk(0, 0, 0,      0, 0, 0,      4, 3,  1, 4, 'h22,   1, 0,  1, 'h22,   0, 0);
    vecs[3]  = mk(0, 0, 0,      0, 0, 0,      4, 0,  0, 4, 'h22,   1, 0,  0, 0,      0, 0);
    vecs[4]  = mk(0, 0, 0,      1, 7, 'hAAAA, 7, 0,  0, 4, 'h22,   1, 1,  1, 'hAAAA, 0, 0);
    vecs[5]  = mk(1, 7, 'hBBBB, 0, 0, 0,      7, 0,  1, 7, 'hBBBB, 1, 1,  1, 'hBBBB, 0, 0);
    vecs[6]  = mk(0, 0, 0,      0, 0, 0,      7, 0,  0, 7, 'hBBBB, 1, 0,  0, 0,      0, 0);
    vecs[7]  = mk(1, 1, 5,      1, 9, 0,      0, 0,  1, 1, 5,      1, 1,  0, 0,      0, 0);
    vecs[8]  = mk(1, 1, 6,      1, 9, 1,      0, 0,  1, 1, 6,      1, 2,  0, 0,      0, 0);
    vecs[9]  = mk(0, 0, 0,      1, 9, 2,      0, 9,  1, 9, 0,      1, 2,  0, 0,      1, 2);
    vecs[10] = mk(0, 0, 0,      0, 0, 0,      9, 9,  1, 9, 1,      1, 1,  1, 2,      1, 2);
    vecs[11] = mk(0, 0, 0,      0, 0, 0,      9, 9,  1, 9, 2,      1, 0,  1, 2,      1, 2);
    vecs[12] = mk(0, 0, 0,      0, 0, 0,      9, 9,  0, 9, 2,      1, 0,  0, 0,      0, 0);
    vecs[13] = mk(1, 0, 'hDEAD, 1, 0, 1,      9, 0,  0, 9, 2,      1, 0,  0, 0,      0, 0);

    // Reset
    step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    step(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'd9, 5'd0, 5'd0);

    // Directed table: priority, squash, forwarding order, x0 handling
    w7 = 0;
    for (int i = 0; i < 14; i++) begin
      step(1'b0, vecs[i].av, vecs[i].ard, vecs[i].ad, vecs[i].mv, vecs[i].mrd,
           vecs[i].md, vecs[i].rs1, vecs[i].rs2);
      check("vec_RegWrite", 32'(RegWrite), 32'(vecs[i].e_rw));
      check("vec_WriteRegister", 32'(WriteRegister), 32'(vecs[i].e_wr));
      check("vec_WriteData", WriteData, vecs[i].e_wd);
      check("vec_mem_ready", 32'(mem_ready), 32'(vecs[i].e_rdy));
      check("vec_pending_cnt", 32'(pending_cnt), 32'(vecs[i].e_cnt));
      check("vec_fwd_hit1", 32'(fwd_hit1), 32'(vecs[i].e_h1));
      check("vec_fwd_data1", fwd_data1, vecs[i].e_d1);
      check("vec_fwd_hit2", 32'(fwd_hit2), 32'(vecs[i].e_h2));
      check("vec_fwd_data2", fwd_data2, vecs[i].e_d2);
    end
    check("squash_x7_write_count", 32'(w7), 32'd1);
    check("squash_x7_final", dut_rf[7], 32'hBBBB);

    // Back-pressure: ALU holds the port while the queue fills
    k = 0;
    for (int c = 0; c < 6; c++) begin
      bit rdy;
      rdy = (mq.size() < DEPTH);
      step(1'b0, 1'b1, 5'd1, 32'(c), 1'b1, 5'(8 + k), 32'h100 + 32'(k), 5'd0, 5'd0);
      if (rdy) k++;
      if (c == 3) check("bp_ready_low_after_4", 32'(mem_ready), 32'd0);
    end
    check("bp_cnt_full", 32'(pending_cnt), 32'd4);
    wlog.delete();
    for (int c = 0; c < 8; c++) begin
      bit rdy;
      rdy = (mq.size() < DEPTH);
      if (k < 5) begin
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'(8 + k), 32'h100 + 32'(k), 5'd0, 5'd0);
        if (rdy) k++;
      end else begin
        idle(5'd0, 5'd0);
      end
    end
    check("bp_drain_writes", 32'(wlog.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      logic [36:0] w;
      w = (i < wlog.size()) ? wlog[i] : 37'd0;
      check("bp_drain_rd", 32'(w[36:32]), 32'(8 + i));
      check("bp_drain_data", w[31:0], 32'h100 + 32'(i));
    end

    // Reset in the middle of activity
    for (int c = 0; c < 3; c++)
      step(1'b0, 1'b1, 5'd1, 32'h55, 1'b1, 5'(20 + c), 32'(c), 5'd0, 5'd0);
    check("mid_cnt_before", 32'(pending_cnt), 32'd3);
    check("mid_rw_before", 32'(RegWrite), 32'd1);
    step(1'b1, 1'b1, 5'd2, 32'h66, 1'b1, 5'd23, 32'h77, 5'd20, 5'd21);
    check("mid_rw_after", 32'(RegWrite), 32'd0);
    check("mid_cnt_after", 32'(pending_cnt), 32'd0);
    for (int c = 0; c < 3; c++) begin
      idle(5'd20, 5'd1);
      check("mid_no_write", 32'(RegWrite), 32'd0);
      check("mid_ready", 32'(mem_ready), 32'd1);
    end

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      step(($urandom_range(0, 99) == 0),
           ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 15)), $urandom,
           ($urandom_range(0, 9) < 6), 5'($urandom_range(0, 15)), $urandom,
           5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
